// File: rtl/next_pc_gen.sv
// Fetch sequencer closing the loop with the external PC register: fetches the word at PC,
// presents it to decode, and returns the next PC (hold, +STEP, or branch redirect).
module next_pc_gen #(
  parameter logic [15:0] STEP     = 16'd4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] PC,
  output logic [15:0] nextPC,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_pc_q, redir_pc_d;
  logic [15:0] next_pc;
  logic        req;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    redir_pend_d  = redir_pend_q;
    redir_pc_d    = redir_pc_q;
    next_pc       = PC;
    req           = 1'b0;

    case (state_q)
      ST_RST: begin
        next_pc = RESET_PC;
        state_d = ST_REQ;
      end

      ST_REQ: begin
        req = 1'b1;
        if (imem_ready) begin
          // A redirect seen during this fetch makes the returned word stale.
          if (redir_pend_q || branch_taken) begin
            next_pc      = branch_taken ? branch_target : redir_pc_q;
            redir_pend_d = 1'b0;
          end else begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end else if (branch_taken) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = branch_target;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          next_pc       = branch_target;
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end else if (instr_accept && !stall) begin
          next_pc       = PC + STEP;
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end
      end

      default: state_d = ST_RST;
    endcase

    if (reset) begin
      next_pc = RESET_PC;
      req     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RST;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      redir_pend_q  <= 1'b0;
      redir_pc_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      redir_pend_q  <= redir_pend_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign nextPC      = next_pc;
  assign imem_req    = req;
  assign imem_addr   = PC;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_next_pc_gen.sv
// Bench for next_pc_gen: closes the PC loop, models a variable-latency instruction memory,
// and scoreboards every instruction presentation against the expected (PC, word) pair.
module tb_next_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int cnt   = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  next_pc_gen dut (
    .clock         (clk),
    .reset         (reset),
    .PC            (pc),
    .nextPC        (next_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_accept  (instr_accept),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0004: return 16'h2222;
      16'h0008: return 16'h3333;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // PC register and memory with a wait of 'lat' cycles per request.
  always @(posedge clk) pc <= next_pc;

  assign imem_ready = imem_req && (cnt >= lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (!imem_req || imem_ready) cnt <= 0;
    else                         cnt <= cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic push_exp(input logic [15:0] a);
    exp_t e;
    e.pc  = a;
    e.ins = mem_word(a);
    exp_q.push_back(e);
  endtask

  // Scoreboard: every rising instr_valid must match the oldest expected fetch.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && valid_prev !== 1'b1) begin
      check_eq("sb_nonempty", 16'(exp_q.size() > 0), 16'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_pc", pc, e.pc);
        check_eq("sb_instr", instr, e.ins);
      end
    end
    valid_prev = instr_valid;
  end

  initial begin
    reset         = 1'b1;
    instr_accept  = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    lat           = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_nextpc", next_pc, 16'h0000);
    check_eq("rst_req", 16'(imem_req), 16'd0);
    check_eq("rst_valid", 16'(instr_valid), 16'd0);
    check_eq("rst_instr", instr, 16'h0000);

    // Zero-wait sequential run with accept held high.
    reset        = 1'b0;
    instr_accept = 1'b1;
    push_exp(16'h0000);
    push_exp(16'h0004);
    push_exp(16'h0008);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("seq_req", 16'(imem_req), 16'd1);
      check_eq("seq_addr", imem_addr, pc);
      check_eq("seq_pc", pc, 16'(4 * i));
      check_eq("seq_hold_pc", next_pc, pc);
      @(negedge clk);
      check_eq("seq_valid", 16'(instr_valid), 16'd1);
      check_eq("seq_hold_req", 16'(imem_req), 16'd0);
      if (i == 2) begin
        instr_accept = 1'b0;
        #1 check_eq("noacc_nextpc", next_pc, pc);
      end else begin
        check_eq("seq_inc", next_pc, pc + 16'd4);
      end
    end

    // Stall blocks accept; then the delayed-memory fetch at 000C.
    stall        = 1'b1;
    instr_accept = 1'b1;
    lat          = 3;
    repeat (4) begin
      @(negedge clk);
      check_eq("stall_instr", instr, 16'h3333);
      check_eq("stall_pc", pc, 16'h0008);
      check_eq("stall_nextpc", next_pc, 16'h0008);
    end
    stall = 1'b0;
    push_exp(16'h000C);
    #1 check_eq("unstall_nextpc", next_pc, 16'h000C);
    @(negedge clk);
    check_eq("unstall_pc", pc, 16'h000C);
    instr_accept = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("wait_req", 16'(imem_req), 16'd1);
      check_eq("wait_addr", imem_addr, 16'h000C);
      check_eq("wait_nextpc", next_pc, 16'h000C);
      check_eq("wait_valid", 16'(instr_valid), 16'd0);
      @(negedge clk);
    end
    check_eq("ready_valid", 16'(instr_valid), 16'd0);
    check_eq("ready_nextpc", next_pc, 16'h000C);
    @(negedge clk);
    check_eq("late_valid", 16'(instr_valid), 16'd1);

    // Branch in HOLD together with accept: branch wins.
    lat           = 0;
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    instr_accept  = 1'b1;
    push_exp(16'h0040);
    #1 check_eq("br_hold_nextpc", next_pc, 16'h0040);
    @(negedge clk);
    branch_taken = 1'b0;
    instr_accept = 1'b0;
    check_eq("br_hold_addr", imem_addr, 16'h0040);
    check_eq("br_hold_req", 16'(imem_req), 16'd1);
    check_eq("br_hold_valid", 16'(instr_valid), 16'd0);
    @(negedge clk);
    check_eq("br_tgt_valid", 16'(instr_valid), 16'd1);

    // Two branches during a 2-cycle-wait fetch at 0004: latest wins, data discarded.
    lat           = 2;
    branch_taken  = 1'b1;
    branch_target = 16'h0004;
    @(negedge clk);
    check_eq("redir_addr", imem_addr, 16'h0004);
    branch_target = 16'h0080;
    #1 check_eq("redir1_nextpc", next_pc, 16'h0004);
    @(negedge clk);
    branch_target = 16'h00C0;
    #1 check_eq("redir2_nextpc", next_pc, 16'h0004);
    @(negedge clk);
    branch_taken = 1'b0;
    #1 check_eq("redir_apply", next_pc, 16'h00C0);
    check_eq("redir_nostale", 16'(instr_valid), 16'd0);
    lat = 0;
    push_exp(16'h00C0);
    @(negedge clk);
    check_eq("redir_fetch", imem_addr, 16'h00C0);
    check_eq("redir_valid", 16'(instr_valid), 16'd0);
    @(negedge clk);
    check_eq("redir_tvalid", 16'(instr_valid), 16'd1);

    // Wrap from FFFC.
    branch_taken  = 1'b1;
    branch_target = 16'hFFFC;
    push_exp(16'hFFFC);
    @(negedge clk);
    branch_taken = 1'b0;
    check_eq("wrap_addr", imem_addr, 16'hFFFC);
    @(negedge clk);
    instr_accept = 1'b1;
    lat          = 5;
    #1 check_eq("wrap_nextpc", next_pc, 16'h0000);

    // Reset mid-fetch with a redirect pending.
    @(negedge clk);
    instr_accept  = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    check_eq("mid_addr", imem_addr, 16'h0000);
    @(negedge clk);
    branch_taken = 1'b0;
    reset        = 1'b1;
    #1 check_eq("mid_rst_nextpc", next_pc, 16'h0000);
    @(negedge clk);
    check_eq("mid_rst_req", 16'(imem_req), 16'd0);
    check_eq("mid_rst_valid", 16'(instr_valid), 16'd0);
    check_eq("mid_rst_instr", instr, 16'h0000);
    reset = 1'b0;
    lat   = 0;
    push_exp(16'h0000);
    @(negedge clk);
    check_eq("restart_req", 16'(imem_req), 16'd1);
    check_eq("restart_addr", imem_addr, 16'h0000);
    @(negedge clk);
    check_eq("restart_valid", 16'(instr_valid), 16'd1);
    repeat (2) @(negedge clk);
    check_eq("restart_hold", pc, 16'h0000);
    check_eq("sb_drain", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/next_pc_gen.md
# next_pc_gen

Fetch sequencer on the far side of the `PC` register. It takes the current `PC`, fetches the instruction at that address from instruction memory over a req/ready handshake, and presents the instruction to decode over a valid/accept handshake. It returns `nextPC` to the `PC` register: hold, sequential increment, or branch redirect. `PC` and `next_pc_gen` form a loop, and `PC` loads `nextPC` on every rising `clock`.

## Interface
- `STEP`, 16'd4, sequential PC increment.
- `RESET_PC`, 16'h0000, value driven on `nextPC` during reset; must equal the `PC` register reset value.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `PC` in 16: current PC from the `PC` register.
- `nextPC` out 16: next PC, fed to the `PC` register; combinational from state and inputs.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out 16: fetch address, always equal to `PC`.
- `imem_ready` in 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 16: fetched instruction word.
- `instr` out 16: registered instruction to decode.
- `instr_valid` out 1: `instr` is valid.
- `instr_accept` in 1: decode consumes `instr`.
- `stall` in 1: pipeline stall; blocks consumption.
- `branch_taken` in 1: single-cycle redirect request.
- `branch_target` in 16: redirect address, sampled with `branch_taken`.

## Operation
- States:
  - RST: entered while `reset` is high.
  - REQ: fetching.
  - HOLD: instruction presented to decode.
- Registers:
  - `state`.
  - `instr`.
  - `redir_pend` (1 bit) and `redir_pc` (16 bits), the buffered redirect.
- Reset:
  - `state`=RST.
  - `instr_valid`=0, `instr`=0, `imem_req`=0, `redir_pend`=0.
  - `nextPC`=`RESET_PC`.
- RST -> REQ on the first edge with `reset` low. In RST, `nextPC`=`RESET_PC`.
- REQ:
  - `imem_req`=1 and `imem_addr`=`PC`.
  - `nextPC`=`PC` (hold) unless noted below.
  - `branch_taken` with `imem_ready` low: the request is not aborted. Set `redir_pend`=1 and `redir_pc`=`branch_target`. A later branch overwrites the pending one (latest wins).
  - `imem_ready` high with no redirect (neither pending nor arriving this cycle): capture `imem_rdata` into `instr` and go to HOLD.
  - `imem_ready` high with a redirect pending or arriving this cycle: discard `imem_rdata`.
    - `nextPC` = arriving `branch_target` if present, otherwise `redir_pc`.
    - Clear `redir_pend` and stay in REQ.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - `branch_taken` (any `stall`/`accept`): `nextPC`=`branch_target`, `instr_valid` falls, go to REQ. Branch has priority over accept.
  - Otherwise, `instr_accept`=1 and `stall`=0: `nextPC`=`PC`+`STEP`, go to REQ.
  - Otherwise: `nextPC`=`PC` and `instr` is held stable.
- Arithmetic: `PC`+`STEP` is mod 2^16, so 16'hFFFC+4 = 16'h0000. `branch_target` is used unaligned, unchecked.
- `reset` asserted in any state, including mid-fetch or with a redirect pending: on that edge, return to RST and clear all state. Any memory response is ignored.

## Timing
- First `imem_req` is in the first cycle after the edge where `reset` is sampled low.
- Zero-wait memory (`imem_ready`=1 in the first REQ cycle): `instr_valid` rises 1 cycle after the REQ cycle.
- Throughput: with zero-wait memory and accept in the first HOLD cycle, 2 cycles per instruction.
- `PC` changes only on edges where `nextPC`≠`PC`: accept, redirect, or reset exit to `RESET_PC`.
- A redirect in HOLD takes effect on the same edge. The fetch from the target starts the next cycle.
- A redirect arriving during REQ takes effect on the edge where `imem_ready` is high. No stale instruction ever reaches `instr_valid`.
- `instr` and `instr_valid` are registered. `nextPC`, `imem_req` and `imem_addr` are combinational from `state` and the registered/input values.

## Test plan
- Reset then run, zero-wait memory returning 16'h1111, 16'h2222, 16'h3333, accept always 1:
  - `PC` sequence 0000 (after reset), 0004, 0008.
  - `instr` presented 1111, 2222, 3333, one every 2 cycles.
  - `imem_addr` matches `PC` each REQ cycle.
- Memory ready delayed 3 cycles:
  - `imem_req` held high with `imem_addr`=`PC` for 3 cycles.
  - `nextPC`=`PC` throughout.
  - `instr_valid` rises 1 cycle after ready.
- In HOLD, `stall`=1 and `instr_accept`=1 for 4 cycles:
  - `instr` and `PC` stable.
  - `stall` drop -> `PC` advances by 4 at the next edge.
- Branch in HOLD with accept same cycle, target 16'h0040: `nextPC`=0040, next fetch at 0040, no fetch at PC+4.
- Branch to 16'h0080 during a 2-cycle-wait fetch at 0004, then a second branch to 16'h00C0 before ready:
  - Data at 0004 discarded; `instr_valid` never rises for it.
  - Next fetch address is 00C0.
- `PC`=16'hFFFC accepted -> `nextPC`=16'h0000.
- `reset` pulsed mid-fetch with a redirect pending: all outputs return to reset values and fetch restarts at 0000.
